fetch_decode_ctrl: RTL and testbench
====================================

// Module: fetch_decode_ctrl
// PURPOSE
// Sequencer for the fetch/decode front end. Drives the load/clear strobes of the
// fetch (PIPO1) and decode (dff) instruction registers, the PC load/select, and the
// isBranchTaken/clrBrnchTrgt controls of the decode stage. Handles fetch-wait
// bubbles, hazard stalls, branch redirect with flush, and HALT.
// PARAMETERS
// BRANCH_OP     5'd16  opcode treated as conditional branch
// HALT_OP       5'd31  opcode that halts the front end
// FLUSH_CYCLES  2      cycles of clrInst after redirect (legal range 1..7)
// CNT_W         16     perf counter width (PERF_CNT_EN only)
// PORTS
// clk            in   1      clock, posedge
// clr            in   1      async active-high reset
// opcode         in   5      opcode of instruction in decode register
// brCond         in   1      branch condition true (valid same cycle as opcode)
// hazStall       in   1      hazard unit stall request
// instRdy        in   1      instruction memory data valid on readInst
// instReq        out  1      fetch request to instruction memory
// ldPC           out  1      PC register load enable
// pcSel          out  1      0: PC+4, 1: branchTarget
// ldInst         out  1      fetch register load
// clrInst        out  1      fetch register clear
// ldDecodeInst   out  1      decode register load
// clrDecodeInst  out  1      decode register clear
// isBranchTaken  out  1      latch branchTarget in decode stage
// clrBrnchTrgt   out  1      clear branchTarget
// halted         out  1      front end halted
// state          out  3      FSM state, debug
// BEHAVIOUR
// - States: INIT=0, RUN=1, REDIR=2, FLUSH=3, HALT=4. clr -> INIT immediately.
// - All outputs combinational from state + inputs; values in INIT (hence under reset):
//   clrInst=clrDecodeInst=clrBrnchTrgt=1, all others 0, state=0. INIT lasts 1 cycle -> RUN.
// - RUN priority (highest first):
//   1 hazStall=1: hold; ldPC=ldInst=ldDecodeInst=0, instReq=1, stay RUN. Branch/HALT in
//     decode wait until stall drops.
//   2 opcode==HALT_OP: all ld*=0, instReq=0 -> HALT.
//   3 opcode==BRANCH_OP & brCond: isBranchTaken=1, ld*=0, instReq=0 -> REDIR.
//   4 instRdy=0: bubble; ldPC=ldInst=0, ldDecodeInst=0, clrDecodeInst=1, instReq=1.
//   5 else: ldPC=ldInst=ldDecodeInst=1, pcSel=0, instReq=1.
//   BRANCH_OP with brCond=0 is case 4/5 (falls through as normal instruction).
// - REDIR (1 cycle; branchTarget now valid): ldPC=1, pcSel=1, clrInst=1, clrDecodeInst=1,
//   instReq=0; load flush counter with FLUSH_CYCLES-1 -> FLUSH, or -> RUN if FLUSH_CYCLES=1.
// - FLUSH: clrInst=1, clrDecodeInst=1, instReq=1, ldPC=0; counter decrements each cycle;
//   at counter==0 -> RUN. hazStall ignored in REDIR/FLUSH. Counter 3 bits, no wrap.
// - HALT: all ld*=0, instReq=0, halted=1; exits only via clr.
// - clr mid-REDIR/FLUSH: counter -> 0, state INIT; redirect abandoned, branchTarget cleared.
// - clr and ld strobes never asserted together on the same register.
// - Branch latency: branch in decode -> first target-path instruction in fetch reg
//   2+FLUSH_CYCLES cycles later (instRdy=1).
// CONFIGURATION
// - PERF_CNT_EN defined: adds outputs stallCount[CNT_W-1:0], flushCount[CNT_W-1:0].
//   stallCount +1 per RUN cycle with hazStall=1 or case 4; flushCount +1 per REDIR/FLUSH
//   cycle. Both saturate at all-ones; reset to 0 on clr.
// - PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset: clr=1 2 cycles, release -> 1 cycle clrInst=clrDecodeInst=clrBrnchTrgt=1, then
//   RUN with ldPC=ldInst=ldDecodeInst=1 when instRdy=1.
// - Taken branch: opcode=16, brCond=1 -> isBranchTaken=1 that cycle; next cycle ldPC=1,
//   pcSel=1; then 1 FLUSH cycle (FLUSH_CYCLES=2) -> RUN; state seq 1,2,3,1.
// - Not-taken: opcode=16, brCond=0, instRdy=1 -> normal advance, isBranchTaken=0.
// - Stall vs branch: opcode=16, brCond=1, hazStall=1 for 3 cycles -> no isBranchTaken,
//   ld*=0; hazStall drop -> isBranchTaken=1 next cycle evaluated.
// - Fetch wait: instRdy=0 2 cycles -> clrDecodeInst=1, ldPC=0 each; stallCount=2 (PERF_CNT_EN).
// - HALT: opcode=31 -> halted=1, instReq=0 held 10 cycles; clr returns to INIT.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode front-end sequencer: register strobes, PC load/select, branch redirect, flush, halt.
// Optional PERF_CNT_EN adds saturating stallCount/flushCount outputs.
module fetch_decode_ctrl #(
    parameter logic [4:0] BRANCH_OP    = 5'd16,
    parameter logic [4:0] HALT_OP      = 5'd31,
    parameter int         FLUSH_CYCLES = 2,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       opcode,
    input  logic             brCond,
    input  logic             hazStall,
    input  logic             instRdy,
    output logic             instReq,
    output logic             ldPC,
    output logic             pcSel,
    output logic             ldInst,
    output logic             clrInst,
    output logic             ldDecodeInst,
    output logic             clrDecodeInst,
    output logic             isBranchTaken,
    output logic             clrBrnchTrgt,
    output logic             halted,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        RUN   = 3'd1,
        REDIR = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);

    state_t     cur, nxt;
    logic [2:0] cnt;
    logic       stall_evt, flush_evt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur <= INIT;
            cnt <= '0;
        end else begin
            cur <= nxt;
            if (cur == REDIR)
                cnt <= FLUSH_LD;
            else if (cur == FLUSH && cnt != 3'd0)
                cnt <= cnt - 3'd1;
        end
    end

    always_comb begin
        nxt           = cur;
        instReq       = 1'b0;
        ldPC          = 1'b0;
        pcSel         = 1'b0;
        ldInst        = 1'b0;
        clrInst       = 1'b0;
        ldDecodeInst  = 1'b0;
        clrDecodeInst = 1'b0;
        isBranchTaken = 1'b0;
        clrBrnchTrgt  = 1'b0;
        halted        = 1'b0;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;
        case (cur)
            INIT: begin
                clrInst       = 1'b1;
                clrDecodeInst = 1'b1;
                clrBrnchTrgt  = 1'b1;
                nxt           = RUN;
            end
            RUN: begin
                if (hazStall) begin
                    instReq   = 1'b1;
                    stall_evt = 1'b1;
                end else if (opcode == HALT_OP) begin
                    nxt = HALT;
                end else if (opcode == BRANCH_OP && brCond) begin
                    isBranchTaken = 1'b1;
                    nxt           = REDIR;
                end else if (!instRdy) begin
                    instReq       = 1'b1;
                    clrDecodeInst = 1'b1;
                    stall_evt     = 1'b1;
                end else begin
                    instReq      = 1'b1;
                    ldPC         = 1'b1;
                    ldInst       = 1'b1;
                    ldDecodeInst = 1'b1;
                end
            end
            REDIR: begin
                ldPC          = 1'b1;
                pcSel         = 1'b1;
                clrInst       = 1'b1;
                clrDecodeInst = 1'b1;
                flush_evt     = 1'b1;
                nxt           = (FLUSH_LD == 3'd0) ? RUN : FLUSH;
            end
            FLUSH: begin
                instReq       = 1'b1;
                clrInst       = 1'b1;
                clrDecodeInst = 1'b1;
                flush_evt     = 1'b1;
                // cnt holds flush cycles remaining including this one
                if (cnt <= 3'd1)
                    nxt = RUN;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: nxt = INIT;
        endcase
    end

    assign state = cur;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stall_evt && stallCount != {CNT_W{1'b1}})
                stallCount <= stallCount + 1'b1;
            if (flush_evt && flushCount != {CNT_W{1'b1}})
                flushCount <= flushCount + 1'b1;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed-vector bench for fetch_decode_ctrl (default parameters).
module tb_fetch_decode_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] opcode;
    logic       brCond, hazStall, instRdy;
    logic       instReq, ldPC, pcSel, ldInst, clrInst, ldDecodeInst, clrDecodeInst;
    logic       isBranchTaken, clrBrnchTrgt, halted;
    logic [2:0] state;
`ifdef PERF_CNT_EN
    logic [15:0] stallCount, flushCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_decode_ctrl dut (
        .clk(clk), .clr(clr), .opcode(opcode), .brCond(brCond), .hazStall(hazStall),
        .instRdy(instRdy), .instReq(instReq), .ldPC(ldPC), .pcSel(pcSel), .ldInst(ldInst),
        .clrInst(clrInst), .ldDecodeInst(ldDecodeInst), .clrDecodeInst(clrDecodeInst),
        .isBranchTaken(isBranchTaken), .clrBrnchTrgt(clrBrnchTrgt), .halted(halted),
`ifdef PERF_CNT_EN
        .stallCount(stallCount), .flushCount(flushCount),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    // {instReq,ldPC,pcSel,ldInst,clrInst,ldDecodeInst,clrDecodeInst,isBranchTaken,clrBrnchTrgt,halted,state}
    localparam logic [12:0] V_INIT  = 13'b0_0_0_0_1_0_1_0_1_0_000;
    localparam logic [12:0] V_RUN   = 13'b1_1_0_1_0_1_0_0_0_0_001;
    localparam logic [12:0] V_STALL = 13'b1_0_0_0_0_0_0_0_0_0_001;
    localparam logic [12:0] V_BUBL  = 13'b1_0_0_0_0_0_1_0_0_0_001;
    localparam logic [12:0] V_TAKEN = 13'b0_0_0_0_0_0_0_1_0_0_001;
    localparam logic [12:0] V_HOP   = 13'b0_0_0_0_0_0_0_0_0_0_001;
    localparam logic [12:0] V_REDIR = 13'b0_1_1_0_1_0_1_0_0_0_010;
    localparam logic [12:0] V_FLUSH = 13'b1_0_0_0_1_0_1_0_0_0_011;
    localparam logic [12:0] V_HALT  = 13'b0_0_0_0_0_0_0_0_0_1_100;

    function automatic logic [12:0] outs();
        return {instReq, ldPC, pcSel, ldInst, clrInst, ldDecodeInst, clrDecodeInst,
                isBranchTaken, clrBrnchTrgt, halted, state};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // apply inputs after a posedge, check settled outputs on the negedge, advance a cycle
    task automatic step(input string tag, input logic [4:0] op, input logic br,
                        input logic hz, input logic rdy, input logic [12:0] exp);
        opcode = op; brCond = br; hazStall = hz; instRdy = rdy;
        @(negedge clk);
        chk(tag, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; opcode = '0; brCond = 0; hazStall = 0; instRdy = 1;
        @(negedge clk);
        chk("reset", 32'(outs()), 32'(V_INIT));
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b0;
        step("init",       5'd0,  0, 0, 1, V_INIT);
        step("run",        5'd3,  0, 0, 1, V_RUN);
        step("br_nt",      5'd16, 0, 0, 1, V_RUN);
        for (int i = 0; i < 3; i++)
            step("stall_br", 5'd16, 1, 1, 1, V_STALL);
        step("br_taken",   5'd16, 1, 0, 1, V_TAKEN);
        step("redir",      5'd0,  0, 1, 0, V_REDIR);
        step("flush",      5'd0,  0, 1, 0, V_FLUSH);
        step("post_flush", 5'd0,  0, 0, 1, V_RUN);
        step("wait1",      5'd0,  0, 0, 0, V_BUBL);
        step("wait2",      5'd0,  0, 0, 0, V_BUBL);
`ifdef PERF_CNT_EN
        chk("stallCount", 32'(stallCount), 32'd5);
        chk("flushCount", 32'(flushCount), 32'd2);
`endif
        step("br_norrdy",  5'd16, 1, 0, 0, V_TAKEN);
        step("redir2",     5'd0,  0, 0, 1, V_REDIR);
        // async clear mid-flush abandons the redirect
        clr = 1'b1;
        #1;
        chk("clr_flush", 32'(outs()), 32'(V_INIT));
        @(posedge clk); #1;
        clr = 1'b0;
        step("init2",      5'd0,  0, 0, 1, V_INIT);
        step("run2",       5'd0,  0, 0, 1, V_RUN);
        step("halt_stall", 5'd31, 0, 1, 1, V_STALL);
        step("halt_op",    5'd31, 0, 0, 1, V_HOP);
        for (int i = 0; i < 10; i++)
            step("halt_hold", 5'(i * 3), i[0], 0, 1, V_HALT);
        clr = 1'b1;
        #1;
        chk("clr_halt", 32'(outs()), 32'(V_INIT));
        @(posedge clk); #1;
        clr = 1'b0;
        step("init3",      5'd0,  0, 0, 1, V_INIT);
        step("run3",       5'd0,  0, 0, 1, V_RUN);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
